// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-beat imem requests, holds the fetched word
// across decode stalls and squashes wrong-path fetches on redirect. Define FETCH_PERF_EN for fetchCount.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirectPC,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic        imemValid,
    input  logic [31:0] imemRdata,
    output logic [31:0] PC,
    output logic [31:0] inst,
    output logic        instWrite
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetchCount
`endif
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_FLUSH} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_pc_out;
    logic [31:0] r_inst;
    logic [31:0] r_buffer;
    logic        r_inst_write;
    logic        w_deliver;
    logic        w_capture;
    logic [31:0] w_deliver_data;
    logic [31:0] w_target;

    assign w_target = redirectPC & ~32'h3;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) r_state <= S_REQ;
        else       r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
        w_next_state = r_state;
        if (redirect) begin
            case (r_state)
                S_REQ:           w_next_state = imemReady ? S_FLUSH : S_REQ;
                S_WAIT, S_FLUSH: w_next_state = imemValid ? S_REQ : S_FLUSH;
                S_HOLD:          w_next_state = S_REQ;
                default:         w_next_state = S_REQ;
            endcase
        end else begin
            case (r_state)
                S_REQ:   if (imemReady) w_next_state = S_WAIT;
                S_WAIT:  if (imemValid) w_next_state = stall ? S_HOLD : S_REQ;
                S_HOLD:  if (!stall)    w_next_state = S_REQ;
                S_FLUSH: if (imemValid) w_next_state = S_REQ;
                default: w_next_state = S_REQ;
            endcase
        end
    end

    // The state register already reads REQ during reset, so the request is also gated by RSTN.
    always_comb begin
        imemReq        = (r_state == S_REQ) && RSTN;
        w_deliver      = 1'b0;
        w_capture      = 1'b0;
        w_deliver_data = r_buffer;
        if (!redirect) begin
            case (r_state)
                S_WAIT: begin
                    w_deliver      = imemValid && !stall;
                    w_capture      = imemValid && stall;
                    w_deliver_data = imemRdata;
                end
                S_HOLD:  w_deliver = !stall;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_pc         <= RESET_PC;
            r_pc_out     <= RESET_PC;
            r_inst       <= NOP_INST;
            r_inst_write <= 1'b0;
            // NOTE: the one-word buffer is reset too; it is tiny and this keeps X off inst.
            r_buffer     <= '0;
        end else begin
            // NOTE: non-blocking for all state; instWrite defaults low so it is a one-cycle strobe.
            r_inst_write <= 1'b0;
            if (redirect) begin
                r_pc         <= w_target;
                r_pc_out     <= w_target;
                r_inst       <= NOP_INST;
                r_inst_write <= 1'b1;
            end else if (w_deliver) begin
                r_pc_out     <= r_pc;
                r_inst       <= w_deliver_data;
                r_inst_write <= 1'b1;
                r_pc         <= r_pc + 32'd4;
            end
            if (w_capture) r_buffer <= imemRdata;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_count;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN)          r_fetch_count <= '0;
        else if (w_deliver) r_fetch_count <= r_fetch_count + 32'd1;
    end

    assign fetchCount = r_fetch_count;
`endif

    assign imemAddr  = r_pc;
    assign PC        = r_pc_out;
    assign inst      = r_inst;
    assign instWrite = r_inst_write;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: a transaction-level memory/redirect model pushes the
// expected (PC, inst, time) stream; an independent monitor pops on every instWrite.
`timescale 1ns/1ps
module tb_if_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam int          T        = 10;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirectPC = '0;
    logic        imemReady = 1'b0;
    logic        imemValid = 1'b0;
    logic [31:0] imemRdata = '0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] PC;
    logic [31:0] inst;
    logic        instWrite;
`ifdef FETCH_PERF_EN
    logic [31:0] fetchCount;
`endif

    if_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
        .CLK(CLK), .RSTN(RSTN), .stall(stall), .redirect(redirect), .redirectPC(redirectPC),
        .imemReq(imemReq), .imemAddr(imemAddr), .imemReady(imemReady), .imemValid(imemValid),
        .imemRdata(imemRdata), .PC(PC), .inst(inst), .instWrite(instWrite)
`ifdef FETCH_PERF_EN
        , .fetchCount(fetchCount)
`endif
    );

    always #(T/2) CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          nop;
        time         t;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    // Transaction-level model: one outstanding request, one held word, expected next address.
    bit          outstanding = 0;
    bit          out_stale   = 0;
    bit          pending     = 0;
    logic [31:0] out_addr    = '0;
    logic [31:0] pend_addr   = '0;
    logic [31:0] pend_data   = '0;
    logic [31:0] model_pc    = RESET_PC;
    int          mem_cnt     = 0;
    int          lat_lo      = 1;
    int          lat_hi      = 1;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return ((addr * 32'h9E37_79B1) ^ 32'h5A5A_0000) | 32'h8000_0000;
    endfunction

    // Evaluated at negedge with the inputs that the coming posedge will see.
    task automatic model_step();
        bit issue;
        issue = imemReq && imemReady;
        if (imemReq) check(!outstanding && !pending, "no_overlap", {31'b0, outstanding | pending}, 32'd0);
        if (issue) check(imemAddr == model_pc, "imem_addr", imemAddr, model_pc);
        if (redirect) begin
            logic [31:0] tgt;
            tgt = redirectPC & ~32'h3;
            exp_q.push_back('{tgt, NOP, 1'b1, $time + T});
            model_pc = tgt;
            pending  = 0;
            if (imemValid)        outstanding = 0;
            else if (outstanding) out_stale   = 1;
            if (issue) begin
                outstanding = 1;
                out_stale   = 1;
                out_addr    = imemAddr;
                mem_cnt     = $urandom_range(lat_hi, lat_lo);
            end
        end else begin
            if (imemValid) begin
                outstanding = 0;
                if (!out_stale) begin
                    pending   = 1;
                    pend_addr = out_addr;
                    pend_data = imemRdata;
                end
            end
            if (pending && !stall) begin
                exp_q.push_back('{pend_addr, pend_data, 1'b0, $time + T});
                model_pc = pend_addr + 32'd4;
                pending  = 0;
            end
            if (issue) begin
                outstanding = 1;
                out_stale   = 0;
                out_addr    = imemAddr;
                mem_cnt     = $urandom_range(lat_hi, lat_lo);
            end
        end
    endtask

    task automatic mem_drive();
        if (outstanding && mem_cnt > 0) mem_cnt--;
        imemValid = outstanding && (mem_cnt == 0);
        imemRdata = imemValid ? mem_word(out_addr) : $urandom;
    endtask

    // Returns at posedge+1; callers change stall/ready/redirect there.
    task automatic cycle();
        @(negedge CLK);
        model_step();
        @(posedge CLK);
        #1;
        mem_drive();
    endtask

    // Called at posedge+1: asserts reset mid-cycle, checks outputs, releases just after a posedge.
    task automatic do_reset(input string tag);
        #2 RSTN = 1'b0;
        #1;
        check(imemReq == 1'b0,    {tag, "_rst_imemReq"},   {31'b0, imemReq}, 32'd0);
        check(instWrite == 1'b0,  {tag, "_rst_instWrite"}, {31'b0, instWrite}, 32'd0);
        check(PC == RESET_PC,     {tag, "_rst_PC"},        PC, RESET_PC);
        check(inst == NOP,        {tag, "_rst_inst"},      inst, NOP);
        check(imemAddr == RESET_PC, {tag, "_rst_imemAddr"}, imemAddr, RESET_PC);
`ifdef FETCH_PERF_EN
        check(fetchCount == 32'd0, {tag, "_rst_fetchCount"}, fetchCount, 32'd0);
`endif
        exp_q.delete();
        outstanding = 0;
        out_stale   = 0;
        pending     = 0;
        model_pc    = RESET_PC;
        mem_cnt     = 0;
        stall       = 1'b0;
        redirect    = 1'b0;
        imemReady   = 1'b0;
        imemValid   = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RSTN = 1'b1;
        #1;
        check(imemReq == 1'b1, {tag, "_first_req"}, {31'b0, imemReq}, 32'd1);
    endtask

    initial begin : monitor
        logic [31:0] last_pc;
        logic [31:0] last_inst;
        bit          prev_iw;
        bit          prev_nop;
        int unsigned mon_count;
        exp_t        e;
        prev_nop = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RSTN) begin
                last_pc   = RESET_PC;
                last_inst = NOP;
                prev_iw   = 1'b0;
                mon_count = 0;
            end else begin
                if (instWrite) begin
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_instWrite", PC, inst);
                    end else begin
                        e = exp_q.pop_front();
                        check($time == e.t, "instWrite_time", 32'($time), 32'(e.t));
                        check(PC == e.pc,     "PC",   PC, e.pc);
                        check(inst == e.inst, "inst", inst, e.inst);
                        check(!(prev_iw && !prev_nop && !e.nop), "instWrite_back_to_back", 32'd1, 32'd0);
                        if (!e.nop) mon_count++;
                        prev_nop = e.nop;
                    end
                    last_pc   = PC;
                    last_inst = inst;
                end else begin
                    check(PC == last_pc,     "PC_stable",   PC, last_pc);
                    check(inst == last_inst, "inst_stable", inst, last_inst);
                    if (exp_q.size() > 0 && exp_q[0].t <= $time) begin
                        check(1'b0, "missing_instWrite", 32'd0, exp_q[0].pc);
                        void'(exp_q.pop_front());
                    end
                end
                prev_iw = instWrite;
`ifdef FETCH_PERF_EN
                check(fetchCount == mon_count, "fetchCount", fetchCount, mon_count);
`endif
            end
        end
    end

    initial begin : stimulus
        bit last_redir;
        @(posedge CLK);
        #1;

        // 1: back-to-back fetches with 1-cycle memory
        do_reset("t1");
        imemReady = 1'b1;
        lat_lo = 1; lat_hi = 1;
        repeat (8) cycle();

        // 2: stall when the word for 0x4 arrives, held 3 cycles
        do_reset("t2");
        imemReady = 1'b1;
        for (int i = 0; i < 20 && !(outstanding && imemValid && out_addr == 32'h4); i++) cycle();
        check(outstanding && imemValid && out_addr == 32'h4, "t2_reach_resp4", out_addr, 32'h4);
        stall = 1'b1;
        repeat (3) cycle();
        stall = 1'b0;
        repeat (6) cycle();

        // 3: redirect in WAIT before the response
        lat_lo = 3; lat_hi = 3;
        for (int i = 0; i < 20 && !(outstanding && !imemValid); i++) cycle();
        check(outstanding && !imemValid, "t3_reach_wait", {31'b0, outstanding}, 32'd1);
        redirect = 1'b1; redirectPC = 32'h0000_0100;
        cycle();
        redirect = 1'b0;
        repeat (12) cycle();

        // 4: redirect coincident with an accepted request
        lat_lo = 2; lat_hi = 2;
        for (int i = 0; i < 20 && !(imemReq && !outstanding); i++) cycle();
        check(imemReq && !outstanding, "t4_reach_req", {31'b0, imemReq}, 32'd1);
        imemReady = 1'b1; redirect = 1'b1; redirectPC = 32'h0000_0203;
        cycle();
        redirect = 1'b0;
        repeat (12) cycle();

        // 5: fetch at 0xFFFF_FFFC wraps to 0x0
        lat_lo = 1; lat_hi = 2;
        for (int i = 0; i < 20 && !(imemReq && !outstanding); i++) cycle();
        redirect = 1'b1; redirectPC = 32'hFFFF_FFFC;
        cycle();
        redirect = 1'b0;
        repeat (12) cycle();

        // 6: reset while waiting for a response
        lat_lo = 3; lat_hi = 3;
        for (int i = 0; i < 20 && !(outstanding && !imemValid); i++) cycle();
        check(outstanding && !imemValid, "t6_reach_wait", {31'b0, outstanding}, 32'd1);
        do_reset("t6");
        imemReady = 1'b1;
        lat_lo = 1; lat_hi = 1;
        repeat (8) cycle();

        // Randomized traffic: latency, ready, stall and redirects
        lat_lo = 1; lat_hi = 4;
        last_redir = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            stall     = ($urandom_range(0, 99) < 30);
            imemReady = ($urandom_range(0, 99) < 70);
            redirect  = !last_redir && ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 3) == 0) redirectPC = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else                           redirectPC = $urandom;
            last_redir = redirect;
            cycle();
        end

        // Drain: no new requests, no stalls
        stall = 1'b0; redirect = 1'b0; imemReady = 1'b0;
        repeat (10) cycle();
        check(exp_q.size() == 0, "drain_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
